frog_sequencer: RTL

FROG_SEQUENCER -- requirements
Module: frog_sequencer

---
 rtl/frog_pkg.sv | 14 +
 rtl/frog_deser.sv | 60 ++++++
 rtl/frog_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/frog_pkg.sv
// Shared definitions for the frog_chip sequencer: FSM states and default widths.
package frog_pkg;

    localparam int FROG_N     = 8;
    localparam int FROG_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH
    } frog_state_e;

endpackage

// File: rtl/frog_deser.sv
// Packs captured chip bits LSB first into N-bit words and holds the
// finished word in a single valid/ready output buffer.
module frog_deser
    import frog_pkg::*;
#(
    parameter int N = FROG_N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         cap,
    input  logic         bit_in,
    input  logic         last,
    input  logic         word_ready,
    output logic         word_end,
    output logic         word_valid,
    output logic [N-1:0] word_data
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  sh_q;
    logic [IW-1:0] idx_q;
    logic [N-1:0]  buf_q;
    logic          vld_q;

    // The next captured bit closes the current word (full or final partial).
    assign word_end   = (idx_q == IW'(N - 1)) || last;
    assign word_valid = vld_q;
    assign word_data  = buf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
            buf_q <= '0;
            vld_q <= 1'b0;
        end else if (clr) begin
            sh_q  <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else begin
            if (vld_q && word_ready)
                vld_q <= 1'b0;
            if (cap) begin
                if (word_end) begin
                    // Unfilled upper bits of sh_q are still zero, giving the padding.
                    buf_q <= sh_q | ({{(N-1){1'b0}}, bit_in} << idx_q);
                    vld_q <= 1'b1;
                    sh_q  <= '0;
                    idx_q <= '0;
                end else begin
                    sh_q[idx_q] <= bit_in;
                    idx_q       <= idx_q + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frog_sequencer.sv
// Loads program/seed into frog_chip serially, then collects cfg_count output
// bits as N-bit words. FROG_SEQ_ZERO_SEED_GUARD_EN rejects zero-seed jobs.
module frog_sequencer
    import frog_pkg::*;
#(
    parameter int N     = FROG_N,
    parameter int CNT_W = FROG_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N-1:0]     cfg_program,
    input  logic [N-1:0]     cfg_seed,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             abort,
    output logic             chip_load,
    output logic             chip_program,
    output logic             chip_seed,
    output logic             chip_enable,
    input  logic             chip_out,
    output logic             word_valid,
    output logic [N-1:0]     word_data,
    input  logic             word_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    frog_state_e      state_q, state_d;
    logic [N-1:0]     prog_q, seed_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IW-1:0]    lidx_q;
    logic             zero_seed, word_end, deser_clr;

`ifdef FROG_SEQ_ZERO_SEED_GUARD_EN
    assign zero_seed = (cfg_seed == '0);
`else
    assign zero_seed = 1'b0;
`endif

    assign deser_clr = abort && (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        cfg_ready    = 1'b0;
        busy         = 1'b1;
        chip_load    = 1'b0;
        chip_program = 1'b0;
        chip_seed    = 1'b0;
        chip_enable  = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                cfg_ready = !abort;
                if (cfg_valid && !abort) begin
                    if (zero_seed) err     = 1'b1;
                    else           state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                chip_load    = 1'b1;
                chip_program = prog_q[lidx_q];
                chip_seed    = seed_q[lidx_q];
                if (lidx_q == IW'(N - 1))
                    state_d = (cnt_q == '0) ? ST_FLUSH : ST_RUN;
            end
            ST_RUN: begin
                // Hold the chip when the closing bit would land on an unaccepted word.
                chip_enable = !(word_end && word_valid && !word_ready);
                if (chip_enable && cnt_q == CNT_W'(1))
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (!word_valid || word_ready) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (deser_clr) begin
            state_d = ST_IDLE;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_q <= '0;
            seed_q <= '0;
            cnt_q  <= '0;
            lidx_q <= '0;
        end else begin
            if (state_q == ST_IDLE && cfg_valid && cfg_ready && !zero_seed) begin
                prog_q <= cfg_program;
                seed_q <= cfg_seed;
                cnt_q  <= cfg_count;
                lidx_q <= '0;
            end
            if (state_q == ST_LOAD)
                lidx_q <= lidx_q + IW'(1);
            if (chip_enable)
                cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    frog_deser #(.N(N)) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (deser_clr),
        .cap        (chip_enable),
        .bit_in     (chip_out),
        .last       (cnt_q == CNT_W'(1)),
        .word_ready (word_ready),
        .word_end   (word_end),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

endmodule
